fetch_unit: RTL
===============

// Module: fetch_unit
// PURPOSE
//  IF stage of the pipeline: owns the PC, drives the instruction bus and hands fetched
//  instructions to the F/D pipeline register. Feeds i_wait to the hazard unit and obeys
//  its stallF/flushF. Takes branch/jump redirects from execute.
//  Discards in-flight responses made stale by a redirect.
// PARAMETERS
//  XLEN      64             PC/address width
//  PC_RESET  64'h8000_0000  PC after reset
//  NOP_INSN  32'h0000_0013  instruction presented with f_exc (addi x0,x0,0)
// PORTS
//  clk            in   1     clock; all state on posedge
//  reset          in   1     synchronous, active-high
//  stallF         in   1     hazard: hold current fetch output/PC
//  flushF         in   1     hazard: F/D reg squashes this cycle (unit only uses it to not advance)
//  redirect_valid in   1     execute: taken branch/jump this cycle
//  redirect_pc    in   XLEN  redirect target
//  ireq_valid     out  1     ibus request valid; held until iresp_data_ok
//  ireq_addr      out  XLEN  ibus request address (stable while ireq_valid)
//  iresp_data_ok  in   1     ibus response valid, one cycle
//  iresp_data     in   32    ibus read data
//  i_wait         out  1     fetch not ready (to hazard)
//  f_valid        out  1     f_pc/f_instr/f_exc valid for F/D register
//  f_pc           out  XLEN  PC of presented instruction
//  f_instr        out  32    presented instruction
//  f_exc          out  1     misaligned-fetch flag (see CONFIGURATION)
// BEHAVIOUR
//  - Reset values: state=REQ, pc=PC_RESET, buffer empty; f_valid=0, f_exc=0, i_wait=1,
//    ireq_valid=0 in the reset cycle, 1 from first cycle after reset deasserts.
//  - States: REQ (request for pc outstanding), HOLD (insn buffered, blocked by stallF),
//    DRAIN (stale request outstanding; new pc already latched).
//  - REQ: ireq_valid=1, ireq_addr=pc. i_wait=~iresp_data_ok. On data_ok: f_valid=1,
//    f_pc=pc, f_instr=iresp_data (same cycle, combinational pass-through).
//    data_ok & ~stallF -> pc<=pc+4, stay REQ. data_ok & stallF -> buffer insn, go HOLD.
//  - HOLD: ireq_valid=0, i_wait=0, f_valid=1 from buffer; ~stallF -> pc<=pc+4, REQ.
//  - DRAIN: ireq_valid=1 at old address, i_wait=1, f_valid=0; on data_ok drop data, -> REQ.
//  - Handoff rule: an insn is consumed only in a cycle with f_valid & ~stallF & ~redirect_valid.
//  - Redirect priority over everything except reset: pc<=redirect_pc; f_valid forced 0 that
//    cycle. REQ w/o data_ok -> DRAIN; REQ with data_ok -> REQ (data dropped); HOLD -> REQ
//    (buffer cleared); DRAIN -> DRAIN (latest target wins).
//  - Request address never changes while ireq_valid=1 and data_ok not seen.
//  - pc+4 wraps modulo 2^XLEN, no flag.
//  - Reset mid-transaction: ibus is reset by same reset; any outstanding request abandoned.
// CONFIGURATION
//  FETCH_MISALIGN_CHK_EN defined: redirect_pc[1:0]!=0 -> no bus request issued; next cycle
//    state REQ presents f_valid=1, f_exc=1, f_pc=redirect_pc, f_instr=NOP_INSN, i_wait=0;
//    consumed like a normal insn (pc<=pc+4 afterwards; held under stallF).
//  Undefined: no check, address issued as-is, f_exc tied 0.
// TESTING
//  reset 2 cycles, data_ok after 3 cycles -> ireq_addr=8000_0000, i_wait=1 x2 then 0, f_pc=8000_0000
//  back-to-back data_ok, stallF=0 -> f_pc 8000_0000,8000_0004,8000_0008 on consecutive handoffs
//  data_ok while stallF=1 for 2 cycles -> HOLD, f_valid held 1, ireq_valid=0, no pc advance
//  redirect to 8000_0100 while request pending -> DRAIN, stale data dropped, next ireq_addr=8000_0100
//  redirect same cycle as data_ok -> f_valid=0, next ireq_addr=target; 2 redirects in DRAIN -> last wins
//  EN defined, redirect to 8000_0102 -> no ireq, f_exc=1, f_instr=0000_0013; undefined -> ireq_addr=8000_0102

Source files
------------

// File: rtl/fetch_unit.sv
// IF stage: owns the PC, issues instruction-bus requests and presents fetched words to F/D.
// Optional misaligned-target check is compiled in with `define FETCH_MISALIGN_CHK_EN.
module fetch_unit #(
  parameter int unsigned     XLEN     = 64,
  parameter logic [XLEN-1:0] PC_RESET = 64'h8000_0000,
  parameter logic [31:0]     NOP_INSN = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stallF,
  input  logic            flushF,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            ireq_valid,
  output logic [XLEN-1:0] ireq_addr,
  input  logic            iresp_data_ok,
  input  logic [31:0]     iresp_data,
  output logic            i_wait,
  output logic            f_valid,
  output logic [XLEN-1:0] f_pc,
  output logic [31:0]     f_instr,
  output logic            f_exc,
  output logic [1:0]      state_dbg
);

  // Handshake: a request is issued while ireq_valid=1; ireq_addr is held stable until the
  // single-cycle iresp_data_ok. An instruction is consumed when f_valid & ~stallF & ~flushF
  // & ~redirect_valid in the same cycle.
  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_HOLD  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t          state, state_n;
  logic [XLEN-1:0] pc, pc_n;
  logic [XLEN-1:0] req_addr, req_addr_n;
  logic [31:0]     buf_insn, buf_insn_n;
  logic            exc_pend, exc_pend_n;
  logic            redirect_misaligned;
  logic            hold;
  logic [XLEN-1:0] pc_plus4;

`ifdef FETCH_MISALIGN_CHK_EN
  assign redirect_misaligned = (redirect_pc[1:0] != 2'b00);
`else
  assign redirect_misaligned = 1'b0;
`endif

  assign hold      = stallF | flushF;
  assign pc_plus4  = pc + XLEN'(4);
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_REQ;
      pc       <= PC_RESET;
      req_addr <= PC_RESET;
      buf_insn <= '0;
      exc_pend <= 1'b0;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      req_addr <= req_addr_n;
      buf_insn <= buf_insn_n;
      exc_pend <= exc_pend_n;
    end
  end

  always_comb begin
    state_n    = state;
    pc_n       = pc;
    req_addr_n = req_addr;
    buf_insn_n = buf_insn;
    exc_pend_n = exc_pend;
    ireq_valid = 1'b0;
    ireq_addr  = pc;
    i_wait     = 1'b1;
    f_valid    = 1'b0;
    f_pc       = pc;
    f_instr    = buf_insn;
    f_exc      = 1'b0;

    case (state)
      S_REQ: begin
        if (exc_pend) begin
          // Misaligned target: present a flagged NOP instead of touching the bus.
          i_wait  = 1'b0;
          f_valid = ~redirect_valid;
          f_exc   = 1'b1;
          f_instr = NOP_INSN;
          if (redirect_valid) begin
            pc_n       = redirect_pc;
            exc_pend_n = redirect_misaligned;
          end else if (!hold) begin
            pc_n       = pc_plus4;
            exc_pend_n = 1'b0;
          end
        end else begin
          ireq_valid = 1'b1;
          req_addr_n = pc;
          i_wait     = ~iresp_data_ok;
          f_instr    = iresp_data;
          f_valid    = iresp_data_ok & ~redirect_valid;
          if (redirect_valid) begin
            pc_n       = redirect_pc;
            exc_pend_n = redirect_misaligned;
            state_n    = iresp_data_ok ? S_REQ : S_DRAIN;
          end else if (iresp_data_ok) begin
            if (hold) begin
              buf_insn_n = iresp_data;
              state_n    = S_HOLD;
            end else begin
              pc_n = pc_plus4;
            end
          end
        end
      end

      S_HOLD: begin
        i_wait  = 1'b0;
        f_valid = ~redirect_valid;
        if (redirect_valid) begin
          pc_n       = redirect_pc;
          exc_pend_n = redirect_misaligned;
          state_n    = S_REQ;
        end else if (!hold) begin
          pc_n    = pc_plus4;
          state_n = S_REQ;
        end
      end

      S_DRAIN: begin
        // The stale request keeps its original address until the bus answers it.
        ireq_valid = 1'b1;
        ireq_addr  = req_addr;
        if (redirect_valid) begin
          pc_n       = redirect_pc;
          exc_pend_n = redirect_misaligned;
        end
        if (iresp_data_ok) state_n = S_REQ;
      end

      default: begin
        state_n = S_REQ;
      end
    endcase

    if (reset) begin
      ireq_valid = 1'b0;
      i_wait     = 1'b1;
      f_valid    = 1'b0;
      f_exc      = 1'b0;
    end
  end

endmodule
